// File: rtl/reg_bank_pkg.sv
// Shared constants and types for the eight-entry register bank and its read muxes.
package reg_bank_pkg;

    localparam int NUM_REGS   = 8;
    localparam int REG_ADDR_W = 3;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/mux8.sv
// Generic N-bit 8:1 multiplexer used as the read path of the register bank.
module mux8
    import reg_bank_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic [N-1:0] d2,
    input  logic [N-1:0] d3,
    input  logic [N-1:0] d4,
    input  logic [N-1:0] d5,
    input  logic [N-1:0] d6,
    input  logic [N-1:0] d7,
    input  reg_addr_t    sel,
    output logic [N-1:0] y
);

    // Select one of the eight inputs; every select value is covered.
    always_comb begin
        y = d0;
        case (sel)
            3'd0: y = d0;
            3'd1: y = d1;
            3'd2: y = d2;
            3'd3: y = d3;
            3'd4: y = d4;
            3'd5: y = d5;
            3'd6: y = d6;
            3'd7: y = d7;
        endcase
    end

endmodule

// File: rtl/reg_bank8.sv
// Eight-entry N-bit register bank: one synchronous write port, two
// combinational read ports built from mux8, and per-entry "written" flags.
// Entry 0 is hardwired to zero and has no storage.
// Optional build macro REG_BANK8_BYPASS_EN adds write-to-read forwarding
// on both read ports; storage and flags are identical either way.
module reg_bank8
    import reg_bank_pkg::*;
#(
    parameter int N = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            wr_ena,
    input  reg_addr_t       wr_addr,
    input  logic [N-1:0]    wr_data,
    input  reg_addr_t       rd_addr0,
    output logic [N-1:0]    rd_data0,
    input  reg_addr_t       rd_addr1,
    output logic [N-1:0]    rd_data1,
    output logic [NUM_REGS-1:0] written
);

    logic [N-1:0]          entry_q [1:NUM_REGS-1];
    logic [NUM_REGS-1:1]   written_q;
    logic                  wr_hit;
    logic [N-1:0]          mux_data0;
    logic [N-1:0]          mux_data1;

    // A write lands only when enabled, not overridden by clear, and not aimed at entry 0.
    assign wr_hit = wr_ena && !clr && (wr_addr != '0);

    // Storage and written flags: async reset, then clear beats write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k < NUM_REGS; k++) begin
                entry_q[k] <= '0;
            end
            written_q <= '0;
        end else if (clr) begin
            for (int k = 1; k < NUM_REGS; k++) begin
                entry_q[k] <= '0;
            end
            written_q <= '0;
        end else if (wr_hit) begin
            for (int k = 1; k < NUM_REGS; k++) begin
                if (wr_addr == reg_addr_t'(k)) begin
                    entry_q[k]   <= wr_data;
                    written_q[k] <= 1'b1;
                end
            end
        end
    end

    assign written = {written_q, 1'b0};

    mux8 #(.N(N)) u_rd_mux0 (
        .d0  ('0),
        .d1  (entry_q[1]),
        .d2  (entry_q[2]),
        .d3  (entry_q[3]),
        .d4  (entry_q[4]),
        .d5  (entry_q[5]),
        .d6  (entry_q[6]),
        .d7  (entry_q[7]),
        .sel (rd_addr0),
        .y   (mux_data0)
    );

    mux8 #(.N(N)) u_rd_mux1 (
        .d0  ('0),
        .d1  (entry_q[1]),
        .d2  (entry_q[2]),
        .d3  (entry_q[3]),
        .d4  (entry_q[4]),
        .d5  (entry_q[5]),
        .d6  (entry_q[6]),
        .d7  (entry_q[7]),
        .sel (rd_addr1),
        .y   (mux_data1)
    );

`ifdef REG_BANK8_BYPASS_EN
    logic fwd_pending;

    // A pending write to a real entry; a simultaneous clear forwards zero instead.
    assign fwd_pending = wr_ena && (wr_addr != '0);

    // Forward the in-flight write value to any read port addressing the same entry.
    always_comb begin
        rd_data0 = mux_data0;
        rd_data1 = mux_data1;
        if (fwd_pending && (rd_addr0 == wr_addr)) begin
            rd_data0 = clr ? '0 : wr_data;
        end
        if (fwd_pending && (rd_addr1 == wr_addr)) begin
            rd_data1 = clr ? '0 : wr_data;
        end
    end
`else
    assign rd_data0 = mux_data0;
    assign rd_data1 = mux_data1;
`endif

endmodule

// File: tb/tb_reg_bank8.sv
// Self-checking bench for reg_bank8: directed scenarios plus random traffic,
// expectations from an array-based reference model fed through a scoreboard queue.
module tb_reg_bank8;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        wr_ena;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  rd_addr0;
    logic [31:0] rd_data0;
    logic [2:0]  rd_addr1;
    logic [31:0] rd_data1;
    logic [7:0]  written;

    typedef struct {
        string       name;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic [7:0]  expWritten;
    } exp_t;

    exp_t        sbq[$];
    int          total;
    int          bad;
    logic [31:0] modelMem [8];
    logic [7:0]  modelWritten;

    reg_bank8 #(.N(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .wr_ena   (wr_ena),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr0 (rd_addr0),
        .rd_data0 (rd_data0),
        .rd_addr1 (rd_addr1),
        .rd_data1 (rd_data1),
        .written  (written)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void modelClear();
        for (int k = 0; k < 8; k++) modelMem[k] = 32'h0;
        modelWritten = 8'h00;
    endfunction

    // What a read port should show right now, from the model plus current inputs.
    function automatic logic [31:0] modelRead(input logic [2:0] a);
        logic [31:0] v;
        v = (a == 3'd0) ? 32'h0 : modelMem[a];
`ifdef REG_BANK8_BYPASS_EN
        if (wr_ena && wr_addr != 3'd0 && a == wr_addr) v = clr ? 32'h0 : wr_data;
`endif
        return v;
    endfunction

    task automatic applyStimulus(input logic c, input logic we, input logic [2:0] wa,
                                 input logic [31:0] wd, input logic [2:0] a0, input logic [2:0] a1);
        clr      = c;
        wr_ena   = we;
        wr_addr  = wa;
        wr_data  = wd;
        rd_addr0 = a0;
        rd_addr1 = a1;
    endtask

    // Push the expected response for the inputs currently applied.
    task automatic checkOutput(input string name);
        exp_t e;
        e.name       = name;
        e.exp0       = modelRead(rd_addr0);
        e.exp1       = modelRead(rd_addr1);
        e.expWritten = modelWritten;
        sbq.push_back(e);
    endtask

    // Advance one rising edge and apply the bank's rules to the model.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (clr) begin
                modelClear();
            end else if (wr_ena && wr_addr != 3'd0) begin
                modelMem[wr_addr]     = wr_data;
                modelWritten[wr_addr] = 1'b1;
            end
        end
        #1;
    endtask

    // Monitor: at each falling edge, compare every pending expectation with the outputs.
    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            total++;
            if (rd_data0 !== e.exp0) begin
                bad++;
                $display("[TB] FAIL %s rd_data0 got %h want %h", e.name, rd_data0, e.exp0);
            end
            total++;
            if (rd_data1 !== e.exp1) begin
                bad++;
                $display("[TB] FAIL %s rd_data1 got %h want %h", e.name, rd_data1, e.exp1);
            end
            total++;
            if (written !== e.expWritten) begin
                bad++;
                $display("[TB] FAIL %s written got %h want %h", e.name, written, e.expWritten);
            end
        end
    end

    initial begin
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [2:0]  wa;
        logic [31:0] wd;
        logic [31:0] step;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        modelClear();
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 3'd0, 3'd0);

        // Reset held: random reads must all return zero.
        for (int i = 0; i < 4; i++) begin
            ra = 3'($urandom_range(0, 7));
            rb = 3'($urandom_range(0, 7));
            applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, ra, rb);
            checkOutput("reset_hold");
            tick();
        end
        rst_n = 1'b1;
        $display("[TB] reset released");

        // Fill entries 1..7 with k * 0x11111111.
        step = 32'h1111_1111;
        for (int k = 1; k < 8; k++) begin
            applyStimulus(1'b0, 1'b1, 3'(k), step * 32'(k), 3'd0, 3'd0);
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 3'(k), 3'(7 - k));
            checkOutput("fill_read");
            tick();
        end

        // Writes to entry 0 are discarded.
        applyStimulus(1'b0, 1'b1, 3'd0, 32'hDEAD_BEEF, 3'd0, 3'd0);
        checkOutput("addr0_write_cycle");
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 3'd0, 3'd0);
        checkOutput("addr0_read");
        tick();

        // Same-cycle read of the entry being written.
        applyStimulus(1'b0, 1'b1, 3'd3, 32'hA5A5_A5A5, 3'd1, 3'd2);
        tick();
        applyStimulus(1'b0, 1'b1, 3'd3, 32'h5A5A_5A5A, 3'd3, 3'd0);
        checkOutput("same_cycle");
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 3'd3, 3'd3);
        checkOutput("after_write");
        tick();

        // Clear together with a write to entry 5: the write is lost.
        applyStimulus(1'b1, 1'b1, 3'd5, 32'h0000_0077, 3'd5, 3'd1);
        checkOutput("clr_cycle");
        tick();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 3'(k), 3'(k ^ 5));
            checkOutput("after_clr");
            tick();
        end

        // Dual-port aliasing, then a port-1 address change within one cycle.
        applyStimulus(1'b0, 1'b1, 3'd2, 32'h0000_BEEF, 3'd0, 3'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 3'd6, 32'h0000_1234, 3'd0, 3'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 3'd6, 3'd6);
        checkOutput("alias_both6");
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 3'd6, 3'd2);
        checkOutput("alias_port1_to2");
        tick();

        // Random traffic with occasional clears.
        for (int i = 0; i < 60; i++) begin
            wa = 3'($urandom_range(0, 7));
            wd = $urandom;
            ra = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
            rb = 3'($urandom_range(0, 7));
            applyStimulus(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), wa, wd, ra, rb);
            checkOutput("random");
            tick();
        end

        // Reset pulled low mid-write to entry 4; entries clear immediately.
        applyStimulus(1'b0, 1'b1, 3'd4, 32'hCAFE_F00D, 3'd0, 3'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 3'd4, 32'h1357_2468, 3'd1, 3'd3);
        #1;
        rst_n = 1'b0;
        modelClear();
        checkOutput("async_reset");
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 3'd4, 3'd7);
        checkOutput("after_reset_mid_write");
        tick();
        applyStimulus(1'b0, 1'b1, 3'd4, 32'h0BAD_F00D, 3'd2, 3'd4);
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 3'd4, 3'd0);
        checkOutput("write_after_reset");
        tick();

        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain left %0d want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
